// File: rtl/fadd_sample_capture.sv
// fadd_sample_capture: aligns each fadd operand pair with the result LATENCY cycles later and
// buffers {op1, op2, result} in a first-word fall-through FIFO. Optional check: FADD_SAMPLE_ZERO_CHECK_EN.
module fadd_sample_capture #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 16,
    parameter int CW      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [31:0]            op1,
    input  logic [31:0]            op2,
    input  logic [31:0]            result,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [31:0]            out_op1,
    output logic [31:0]            out_op2,
    output logic [31:0]            out_result,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CW-1:0]          drop_count,
    output logic [CW-1:0]          err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    logic          r_vld_p [LATENCY];
    logic [31:0]   r_op1_p [LATENCY];
    logic [31:0]   r_op2_p [LATENCY];

    logic [31:0]   r_mem_op1 [DEPTH];
    logic [31:0]   r_mem_op2 [DEPTH];
    logic [31:0]   r_mem_res [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic [CW-1:0] r_drop_count;

    logic          w_cap;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [31:0]   w_cap_op1;
    logic [31:0]   w_cap_op2;

    // Delay line stage boundary: valids reset, operand fields only load behind a valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++)
                r_vld_p[i] <= 1'b0;
        end else begin
            r_vld_p[0] <= issue_valid;
            for (int i = 1; i < LATENCY; i++)
                r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (issue_valid) begin
            r_op1_p[0] <= op1;
            r_op2_p[0] <= op2;
        end
        for (int i = 1; i < LATENCY; i++) begin
            if (r_vld_p[i-1]) begin
                r_op1_p[i] <= r_op1_p[i-1];
                r_op2_p[i] <= r_op2_p[i-1];
            end
        end
    end

    assign w_cap     = r_vld_p[LATENCY-1];
    assign w_cap_op1 = r_op1_p[LATENCY-1];
    assign w_cap_op2 = r_op2_p[LATENCY-1];

    // A full FIFO still accepts a capture when the head leaves in the same cycle
    assign out_valid = (r_level != '0);
    assign w_full    = (r_level == FULL_LVL);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = w_cap && (!w_full || w_pop);
    assign w_drop    = w_cap && w_full && !w_pop;

    // FIFO storage boundary
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op1[r_wr_ptr] <= w_cap_op1;
            r_mem_op2[r_wr_ptr] <= w_cap_op2;
            r_mem_res[r_wr_ptr] <= result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (w_pop && !w_push)
                r_level <= r_level - LW'(1);
            if (w_drop) begin
                r_overflow   <= 1'b1;
                r_drop_count <= sat_inc(r_drop_count);
            end
        end
    end

    assign out_op1    = out_valid ? r_mem_op1[r_rd_ptr] : 32'd0;
    assign out_op2    = out_valid ? r_mem_op2[r_rd_ptr] : 32'd0;
    assign out_result = out_valid ? r_mem_res[r_rd_ptr] : 32'd0;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

`ifdef FADD_SAMPLE_ZERO_CHECK_EN
    function automatic logic is_zero(input logic [31:0] v);
        return (v[30:0] == 31'd0);
    endfunction

    function automatic logic is_finite_normal(input logic [31:0] v);
        return (v[30:23] != 8'h00) && (v[30:23] != 8'hFF);
    endfunction

    // x + (+/-0) must return x exactly; (+/-0) + (+/-0) is -0 only when both are -0
    function automatic logic zero_mismatch(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] r);
        logic w_az;
        logic w_bz;
        w_az = is_zero(a);
        w_bz = is_zero(b);
        if (w_az && w_bz)
            return r != {a[31] & b[31], 31'd0};
        else if (w_az && is_finite_normal(b))
            return r != b;
        else if (w_bz && is_finite_normal(a))
            return r != a;
        return 1'b0;
    endfunction

    logic [CW-1:0] r_err_count;
    logic          w_zc_err;

    assign w_zc_err = w_cap && zero_mismatch(w_cap_op1, w_cap_op2, result);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_err_count <= '0;
        else if (w_zc_err)
            r_err_count <= sat_inc(r_err_count);
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_fadd_sample_capture.sv
// Scoreboard bench for fadd_sample_capture: a driver models the fadd stub and FIFO occupancy,
// a monitor pops expected triples whenever the DUT hands one over.
`timescale 1ns/1ps
module tb_fadd_sample_capture;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 16;
    localparam int CW      = 16;
    localparam int CMAX    = (1 << CW) - 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   issue_valid = 1'b0;
    logic [31:0]            op1 = 32'd0;
    logic [31:0]            op2 = 32'd0;
    logic [31:0]            result = 32'd0;
    logic                   out_ready = 1'b0;
    logic                   out_valid;
    logic [31:0]            out_op1;
    logic [31:0]            out_op2;
    logic [31:0]            out_result;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic [CW-1:0]          drop_count;
    logic [CW-1:0]          err_count;

    fadd_sample_capture #(.LATENCY(LATENCY), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .op1(op1), .op2(op2),
        .result(result), .out_ready(out_ready), .out_valid(out_valid), .out_op1(out_op1),
        .out_op2(out_op2), .out_result(out_result), .level(level), .overflow(overflow),
        .drop_count(drop_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] r; int due; bit live; } pend_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] r; } trip_t;

    pend_t pend_q[$];
    trip_t exp_q[$];
    int    mlevel = 0;
    bit    movf = 0;
    int    mdrop = 0;
    int    merr = 0;
    int    cyc = 0;
    int    n_vec = 0;
    int    n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit zc_mismatch(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] r);
        bit az = (a[30:0] == 31'd0);
        bit bz = (b[30:0] == 31'd0);
        if (az && bz) return r != {a[31] & b[31], 31'd0};
        if (az && b[30:23] >= 8'd1 && b[30:23] <= 8'd254) return r != b;
        if (bz && a[30:23] >= 8'd1 && a[30:23] <= 8'd254) return r != a;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Stub result: usually the exact zero-identity answer when one applies, otherwise random
    function automatic logic [31:0] rnd_res(input logic [31:0] a, input logic [31:0] b);
        if ($urandom_range(0, 3) == 0) return $urandom;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return {a[31] & b[31], 31'd0};
        if (a[30:0] == 31'd0) return b;
        if (b[30:0] == 31'd0) return a;
        return $urandom;
    endfunction

    task automatic check_state();
        check("out_valid", 64'(out_valid), 64'(mlevel != 0));
        check("level", 64'(level), 64'(mlevel));
        check("overflow", 64'(overflow), 64'(movf));
        check("drop_count", 64'(drop_count), 64'(mdrop));
        check("err_count", 64'(err_count), 64'(merr));
        if (mlevel != 0 && exp_q.size() > 0) begin
            check("head_op1", 64'(out_op1), 64'(exp_q[0].a));
            check("head_op2", 64'(out_op2), 64'(exp_q[0].b));
            check("head_result", 64'(out_result), 64'(exp_q[0].r));
        end else if (mlevel == 0) begin
            check("empty_outs", {out_op1, out_op2}, 64'd0);
            check("empty_result", 64'(out_result), 64'd0);
        end
    endtask

    // One clock cycle, entered at posedge+1: check state, drive inputs, advance the model
    task automatic cycle(input bit iv, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input bit rdy);
        pend_t p;
        trip_t t;
        bit    cap;
        bit    pop;
        bit    acc;
        check_state();
        issue_valid = iv;
        op1 = a;
        op2 = b;
        out_ready = rdy;
        result = $urandom;
        cap = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            p = pend_q.pop_front();
            result = p.r;
            cap = p.live;
            t.a = p.a;
            t.b = p.b;
            t.r = p.r;
        end
        if (iv) begin
            p.a = a; p.b = b; p.r = r; p.due = cyc + LATENCY; p.live = reset;
            pend_q.push_back(p);
        end
        pop = (mlevel > 0) && rdy;
        acc = 1'b0;
        if (cap) begin
`ifdef FADD_SAMPLE_ZERO_CHECK_EN
            if (zc_mismatch(t.a, t.b, t.r) && merr < CMAX) merr++;
`endif
            if (mlevel < DEPTH || pop) begin
                exp_q.push_back(t);
                acc = 1'b1;
            end else begin
                movf = 1'b1;
                if (mdrop < CMAX) mdrop++;
            end
        end
        mlevel = mlevel + int'(acc) - int'(pop);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rnd_cycle(input bit iv, input bit rdy);
        logic [31:0] a;
        logic [31:0] b;
        a = rnd_op();
        b = rnd_op();
        cycle(iv, a, b, rnd_res(a, b), rdy);
    endtask

    // Monitor: every accepted handshake must deliver the oldest expected triple
    initial begin
        trip_t t;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_pop: got %h/%h/%h, expected nothing", out_op1, out_op2, out_result);
                end else begin
                    t = exp_q.pop_front();
                    check("pop_op1", 64'(out_op1), 64'(t.a));
                    check("pop_op2", 64'(out_op2), 64'(t.b));
                    check("pop_result", 64'(out_result), 64'(t.r));
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(1, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 0);
        repeat (4) cycle(0, 0, 0, 0, 0);
        check("t1_level", 64'(level), 64'd1);
        check("t1_head_op2", 64'(out_op2), 64'h3F80_0000);
        check("t1_head_result", 64'(out_result), 64'h3F80_0000);
        repeat (3) cycle(0, 0, 0, 0, 1);

        repeat (20) rnd_cycle(1, 0);
        repeat (LATENCY + 1) cycle(0, 0, 0, 0, 0);
        check("burst_level", 64'(level), 64'd16);
        check("burst_overflow", 64'(overflow), 64'd1);
        check("burst_drops", 64'(drop_count), 64'd4);

        cycle(1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        check("pushpop_level", 64'(level), 64'd16);
        check("pushpop_drops", 64'(drop_count), 64'd4);
        repeat (DEPTH + 4) cycle(0, 0, 0, 0, 1);
        check("drained", 64'(out_valid), 64'd0);

        for (int i = 0; i < 24; i++) rnd_cycle(i % 2 == 0, 1);
        for (int i = 0; i < 300; i++) rnd_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

        repeat (DEPTH + 4) cycle(0, 0, 0, 0, 1);
        repeat (3) rnd_cycle(1, 0);
        repeat (LATENCY) cycle(0, 0, 0, 0, 0);
        repeat (2) rnd_cycle(1, 0);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        mlevel = 0;
        movf = 1'b0;
        mdrop = 0;
        merr = 0;
        exp_q.delete();
        foreach (pend_q[i]) pend_q[i].live = 1'b0;
        #1;
        reset = 1'b1;
        repeat (LATENCY + 3) cycle(0, 0, 0, 0, 1);
        check("post_rst_level", 64'(level), 64'd0);

        cycle(1, 32'h0000_0000, 32'h4049_0FDB, 32'h4049_0FDA, 1);
        cycle(1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1);
        repeat (LATENCY + 2) cycle(0, 0, 0, 0, 1);
`ifdef FADD_SAMPLE_ZERO_CHECK_EN
        check("zc_err_count", 64'(err_count), 64'd1);
`endif
        check_state();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fadd_sample_capture.md
Name: fadd_sample_capture

Overview:
- Capture end of the fadd sample stream; the reader counterpart to the fadd stimulus generator.
- Aligns each issued operand pair with the fadd result that appears LATENCY cycles later.
- Buffers the {op1, op2, result} triples in a FIFO so a drain port (UART dumper or bench) can read them at its own rate.
- Sits beside the fadd instance in the FPU bring-up harness.

Parameters:
- LATENCY, 2: fadd pipeline depth in cycles, range 1..8; operands issued at cycle t produce a result at cycle t+LATENCY.
- DEPTH, 16: FIFO entries, power of two, range 2..256.
- CW, 16: width of the drop and error counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  op1/op2 are being presented to fadd this cycle
- op1  in  32  operand 1 as driven to fadd
- op2  in  32  operand 2 as driven to fadd
- result  in  32  fadd result output
- out_ready  in  1  drain side accepts the head entry
- out_valid  out  1  FIFO not empty
- out_op1  out  32  head entry operand 1
- out_op2  out  32  head entry operand 2
- out_result  out  32  head entry result
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; set when a capture was dropped
- drop_count  out  CW  saturating count of dropped captures
- err_count  out  CW  saturating zero-check mismatch count (optional feature)

Behaviour:
- Reset (reset==0, async): delay line valids, FIFO pointers, level, overflow, drop_count and err_count all clear to 0. out_valid=0 and out_* read as 0 while empty. Reset mid-stream discards all in-flight and buffered entries.
- Delay line: LATENCY stages, each holding {v, op1, op2}, shifting every cycle.
  - Stage 0 loads {issue_valid, op1, op2}.
  - Captured op fields load only when v=1; v always loads.
- Capture event: the last stage has v=1. The triple {stage.op1, stage.op2, result} is pushed in that same cycle.
  - Issue at cycle t gives a push at the clk edge ending cycle t+LATENCY.
  - With issue_valid held high every cycle, one push per cycle.
- FIFO: first-word fall-through.
  - out_* show the head combinationally from storage registers.
  - Pop occurs when out_valid && out_ready.
- Push is accepted when level<DEPTH, or when level==DEPTH and a pop happens in the same cycle. Simultaneous push and pop leaves level unchanged.
- Push while full with no pop: the entry is discarded, overflow is set to 1 (sticky until reset), and drop_count increments, saturating at 2^CW-1.
- Pop while empty: ignored. Level never underflows.
- Pointers are log2(DEPTH) bits and wrap naturally. level is tracked separately so full and empty are distinguished.
- out_valid = (level!=0), registered-state derived with no combinational path from out_ready.
- issue_valid=0 cycles create bubbles that propagate as gaps. Ordering is preserved exactly.

Optional Feature:
- Macro: FADD_SAMPLE_ZERO_CHECK_EN.
- Defined: at each capture event, if exactly one operand has bits[30:0]==0 (±0) and the other has exponent in 1..254, the result must equal the other operand bit-exactly. On mismatch, err_count increments (saturating). The check is performed on the delayed triple. If both operands are ±0, the result must be {op1[31]&op2[31], 31'b0}.
- The check is independent of FIFO acceptance: a dropped entry is still checked.
- Not defined: err_count is tied to 0 and no compare logic is synthesized.

Test Plan:
- LATENCY=2. Issue op1=0x00000000, op2=0x3F800000 at cycle 5; fadd stub returns 0x3F800000 at cycle 7 -> out_valid rises after the cycle-7 edge, head = {0x00000000, 0x3F800000, 0x3F800000}, level=1.
- Issue 20 back-to-back random pairs with out_ready=0, DEPTH=16 -> level saturates at 16, overflow=1, drop_count=4. Then drain with out_ready=1 -> the first 16 triples appear in issue order, then out_valid=0.
- Full FIFO, with a push and pop in the same cycle -> level stays 16, no drop, drop_count unchanged, and the new tail equals the pushed triple.
- Alternate issue_valid 1/0 with out_ready=1 -> captures appear exactly LATENCY cycles after each issue, bubbles are not captured, and no reordering occurs.
- Assert reset low with 3 entries buffered and 2 in flight -> out_valid=0, level=0, overflow=0 immediately. After release, the stub's late results are not captured.
- With FADD_SAMPLE_ZERO_CHECK_EN: op1=0x00000000, op2=0x40490FDB, stub result 0x40490FDA -> err_count=1. Then op1=0x80000000, op2=0x80000000, result 0x80000000 -> err_count stays 1.
